// File: rtl/pc_halt_monitor.sv
// Run-control monitor beside the RV32 writeback stage: counts cycles/retires in RUN and
// freezes on a PC breakpoint, a same-PC self-loop, or a cycle-budget timeout.
module pc_halt_monitor #(
  parameter int PC_W        = 32,
  parameter int NUM_BP      = 4,
  parameter int CNT_W       = 32,
  parameter int LOOP_THRESH = 8,
  parameter int MAX_CYCLES  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   validW,
  input  logic [PC_W-1:0]        pcW,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   running,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [PC_W-1:0]        halt_pc,
  output logic [2:0]             hit_idx,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt
);

  localparam int               REP_W      = $clog2(LOOP_THRESH + 1);
  localparam logic [REP_W-1:0] REP_THRESH = REP_W'(LOOP_THRESH);
  localparam logic [CNT_W-1:0] CYC_LIMIT  = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [PC_W-1:0]   r_last_pc;
  logic [REP_W-1:0]  r_repeat;
  logic [1:0]        r_halt_cause;
  logic [PC_W-1:0]   r_halt_pc;
  logic [2:0]        r_hit_idx;

  logic              w_active;
  logic              w_retire;
  logic              w_bp_hit;
  logic [2:0]        w_bp_idx;
  logic [REP_W-1:0]  w_rep_next;
  logic              w_bp_event;
  logic              w_loop_event;
  logic              w_to_event;
  logic              w_halt;

  // A RUN cycle with en low is a pure pause: nothing is counted or tracked.
  always_comb begin
    w_active = (r_state == S_RUN) && en;
    w_retire = w_active && validW;

    w_bp_hit = 1'b0;
    w_bp_idx = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pcW)) begin
        w_bp_hit = 1'b1;
        w_bp_idx = 3'(i);
      end
    end

    if (pcW != r_last_pc) begin
      w_rep_next = REP_W'(1);
    end else if (&r_repeat) begin
      w_rep_next = r_repeat;
    end else begin
      w_rep_next = r_repeat + 1'b1;
    end

    w_bp_event   = w_retire && w_bp_hit;
    w_loop_event = w_retire && (w_rep_next == REP_THRESH);
    w_to_event   = w_active && (CYC_LIMIT != '0) && (r_cycle_cnt == CYC_LIMIT - 1'b1);
    w_halt       = w_bp_event || w_loop_event || w_to_event;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (en) w_state_next = S_RUN;
      S_RUN: begin
        if (w_halt)   w_state_next = S_HALTED;
        else if (!en) w_state_next = S_IDLE;
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
    if (clear) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_last_pc    <= '0;
      r_repeat     <= '0;
      r_halt_cause <= 2'd0;
      r_halt_pc    <= '0;
      r_hit_idx    <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (w_active && !(&r_cycle_cnt)) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire) begin
        if (!(&r_retire_cnt)) r_retire_cnt <= r_retire_cnt + 1'b1;
        r_last_pc <= pcW;
        r_repeat  <= w_rep_next;
      end
      // Only the highest-priority cause is recorded: breakpoint > self-loop > timeout.
      if (w_bp_event) begin
        r_halt_cause <= 2'd1;
        r_halt_pc    <= pcW;
        r_hit_idx    <= w_bp_idx;
      end else if (w_loop_event) begin
        r_halt_cause <= 2'd2;
        r_halt_pc    <= pcW;
      end else if (w_to_event) begin
        r_halt_cause <= 2'd3;
        r_halt_pc    <= validW ? pcW : r_last_pc;
      end
    end
  end

  assign running    = (r_state == S_RUN);
  assign halted     = (r_state == S_HALTED);
  assign halt_cause = r_halt_cause;
  assign halt_pc    = r_halt_pc;
  assign hit_idx    = r_hit_idx;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pc_halt_monitor.sv
// Bench for pc_halt_monitor: one instance without timeout, one with a 10-cycle budget;
// halt records are pushed to per-instance queues and popped when halted rises.
module tb_pc_halt_monitor;

  localparam int W = 2 + 32 + 3 + 32 + 32;

  logic         clk = 1'b0;
  logic         rst, en0, en1, clear, validW;
  logic [31:0]  pcW;
  logic [127:0] bp_addr;
  logic [3:0]   bp_en;

  logic        running0, halted0, running1, halted1;
  logic [1:0]  cause0, cause1;
  logic [31:0] hpc0, hpc1, cyc0, cyc1, ret0, ret1;
  logic [2:0]  idx0, idx1;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  always #5 clk = ~clk;

  pc_halt_monitor #(.PC_W(32), .NUM_BP(4), .CNT_W(32), .LOOP_THRESH(8), .MAX_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .clear(clear), .validW(validW), .pcW(pcW),
    .bp_addr(bp_addr), .bp_en(bp_en), .running(running0), .halted(halted0),
    .halt_cause(cause0), .halt_pc(hpc0), .hit_idx(idx0), .cycle_cnt(cyc0), .retire_cnt(ret0)
  );

  pc_halt_monitor #(.PC_W(32), .NUM_BP(4), .CNT_W(32), .LOOP_THRESH(8), .MAX_CYCLES(10)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .clear(clear), .validW(validW), .pcW(pcW),
    .bp_addr(bp_addr), .bp_en(bp_en), .running(running1), .halted(halted1),
    .halt_cause(cause1), .halt_pc(hpc1), .hit_idx(idx1), .cycle_cnt(cyc1), .retire_cnt(ret1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] cause, input logic [31:0] pc,
                                      input logic [2:0] idx, input logic [31:0] cyc,
                                      input logic [31:0] ret);
    return {cause, pc, idx, cyc, ret};
  endfunction

  task automatic cmp_halt(input string tag, input logic [W-1:0] e, input logic [1:0] cause,
                          input logic [31:0] pc, input logic [2:0] idx,
                          input logic [31:0] cyc, input logic [31:0] ret);
    chk({tag, "_cause"},   32'(cause), 32'(e[100:99]));
    chk({tag, "_halt_pc"}, pc,         e[98:67]);
    chk({tag, "_hit_idx"}, 32'(idx),   32'(e[66:64]));
    chk({tag, "_cyc_cnt"}, cyc,        e[63:32]);
    chk({tag, "_ret_cnt"}, ret,        e[31:0]);
  endtask

  // Monitor: a rising halted means the DUT is presenting a halt record.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (halted0 === 1'b1 && prev0 === 1'b0) begin
      if (exp_q0.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut0_unexpected_halt actual_cause=%0d expected=no halt", cause0);
      end else begin
        e = exp_q0.pop_front();
        cmp_halt("dut0", e, cause0, hpc0, idx0, cyc0, ret0);
      end
    end
    if (halted1 === 1'b1 && prev1 === 1'b0) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut1_unexpected_halt actual_cause=%0d expected=no halt", cause1);
      end else begin
        e = exp_q1.pop_front();
        cmp_halt("dut1", e, cause1, hpc1, idx1, cyc1, ret1);
      end
    end
    prev0 = halted0;
    prev1 = halted1;
  end

  task automatic cyc(input logic e0, input logic e1, input logic v, input logic [31:0] pc);
    en0 = e0; en1 = e1; validW = v; pcW = pc;
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; en0 = 1'b0; en1 = 1'b0; validW = 1'b0; pcW = '0;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic set_bp(input int ch, input logic [31:0] a);
    bp_addr[ch*32 +: 32] = a;
  endtask

  task automatic check_zero0(input string tag);
    chk({tag, "_running"}, 32'(running0), 0);
    chk({tag, "_halted"},  32'(halted0),  0);
    chk({tag, "_cause"},   32'(cause0),   0);
    chk({tag, "_halt_pc"}, hpc0,          0);
    chk({tag, "_hit_idx"}, 32'(idx0),     0);
    chk({tag, "_cyc_cnt"}, cyc0,          0);
    chk({tag, "_ret_cnt"}, ret0,          0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; clear = 1'b0; validW = 1'b0; pcW = '0;
    bp_addr = '0; bp_en = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero0("reset");
    chk("reset_dut1_halted", 32'(halted1), 0);

    // Breakpoint on channel 0, then retires after the halt are ignored.
    set_bp(0, 32'hc); bp_en = 4'b0001;
    exp_q0.push_back(mk(2'd1, 32'hc, 3'd0, 32'd4, 32'd4));
    cyc(1, 0, 0, 0);
    chk("t1_running", 32'(running0), 1);
    cyc(1, 0, 1, 32'h0); cyc(1, 0, 1, 32'h4); cyc(1, 0, 1, 32'h8); cyc(1, 0, 1, 32'hc);
    chk("t1_halted", 32'(halted0), 1);
    cyc(1, 0, 1, 32'h10); cyc(1, 0, 1, 32'h14);
    chk("t1_frozen_cyc", cyc0, 4);
    chk("t1_frozen_ret", ret0, 4);
    chk("t1_still_halted", 32'(halted0), 1);
    do_clear();
    check_zero0("t1_clear");

    // Multi-hit: lowest enabled channel wins, disabled channel 0 ignored.
    set_bp(0, 32'h20); set_bp(1, 32'h20); set_bp(2, 32'h99); set_bp(3, 32'h20);
    bp_en = 4'b1010;
    exp_q0.push_back(mk(2'd1, 32'h20, 3'd1, 32'd2, 32'd1));
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 32'h20);
    chk("t2_halted", 32'(halted0), 1);
    do_clear();

    // Self-loop broken by a different PC at position 7: no halt.
    bp_en = 4'b0000;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 1, 32'h40); cyc(1, 0, 0, 0);
    end
    cyc(1, 0, 1, 32'h44); cyc(1, 0, 0, 0); cyc(1, 0, 1, 32'h40);
    chk("t3a_no_halt", 32'(halted0), 0);
    chk("t3a_ret_cnt", ret0, 8);
    chk("t3a_cyc_cnt", cyc0, 15);
    do_clear();

    // Self-loop: eight retires of 0x40 separated by idle cycles.
    exp_q0.push_back(mk(2'd2, 32'h40, 3'd0, 32'd15, 32'd8));
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 1, 32'h40);
      if (k < 7) cyc(1, 0, 0, 0);
    end
    chk("t3b_halted", 32'(halted0), 1);
    do_clear();

    // Breakpoint enabled on the very retire that completes a self-loop.
    set_bp(2, 32'h50);
    exp_q0.push_back(mk(2'd1, 32'h50, 3'd2, 32'd8, 32'd8));
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(1, 0, 1, 32'h50);
    bp_en = 4'b0100;
    cyc(1, 0, 1, 32'h50);
    chk("t4_halted", 32'(halted0), 1);
    do_clear();
    bp_en = 4'b0000;

    // Timeout with a pause in the middle (budget 10).
    exp_q1.push_back(mk(2'd3, 32'h108, 3'd0, 32'd10, 32'd3));
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h100); cyc(0, 1, 1, 32'h104); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t5_paused", 32'(running1), 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("t5_pause_cyc", cyc1, 4);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h108);
    repeat (4) cyc(0, 1, 0, 0);
    chk("t5_not_yet", 32'(halted1), 0);
    cyc(0, 1, 0, 0);
    chk("t5_halted", 32'(halted1), 1);
    do_clear();

    // Breakpoint and timeout on the same edge.
    set_bp(0, 32'h200); bp_en = 4'b0001;
    exp_q1.push_back(mk(2'd1, 32'h200, 3'd0, 32'd10, 32'd1));
    cyc(0, 1, 0, 0);
    repeat (9) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h200);
    chk("t6_halted", 32'(halted1), 1);
    do_clear();
    bp_en = 4'b0000;

    // Self-loop and timeout on the same edge.
    exp_q1.push_back(mk(2'd2, 32'h300, 3'd0, 32'd10, 32'd8));
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 1, 32'h300);
    chk("t7_halted", 32'(halted1), 1);
    do_clear();

    // Reset mid-RUN, then a fresh run counts from zero.
    cyc(1, 0, 0, 0); cyc(1, 0, 1, 32'h60); cyc(1, 0, 1, 32'h64);
    rst = 1'b1;
    cyc(1, 0, 1, 32'h68);
    rst = 1'b0;
    check_zero0("t8_rst");
    set_bp(0, 32'h8); bp_en = 4'b0001;
    exp_q0.push_back(mk(2'd1, 32'h8, 3'd0, 32'd1, 32'd1));
    cyc(1, 0, 0, 0); cyc(1, 0, 1, 32'h8);
    chk("t8_halted", 32'(halted0), 1);

    repeat (3) cyc(0, 0, 0, 0);
    chk("q0_drained", 32'(exp_q0.size()), 0);
    chk("q1_drained", 32'(exp_q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_halt_monitor.md
Name: pc_halt_monitor

Overview:
Synthesizable run-control monitor for the pipelined RV32 core. It watches the writeback-stage PC and retire strobe, counts cycles and retired instructions, and freezes the run on one of three conditions: a programmable multi-channel PC breakpoint, a self-loop idle detect, or a cycle-budget timeout. It sits beside the core's writeback stage and is shared by simulation benches and the FPGA debug harness.

Parameters:
PC_W, 32, width of the monitored PC.
NUM_BP, 4, number of breakpoint channels (1..8).
CNT_W, 32, width of the cycle and retire counters.
LOOP_THRESH, 8, consecutive same-PC retires that declare a self-loop (>=2).
MAX_CYCLES, 0, cycle budget for timeout; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  start/continue monitoring
clear  in  1  leave HALTED, zero counters, return to IDLE
validW  in  1  an instruction retires this cycle
pcW  in  PC_W  PC of the retiring instruction
bp_addr  in  NUM_BP*PC_W  breakpoint addresses, channel i at bits [i*PC_W +: PC_W]
bp_en  in  NUM_BP  per-channel breakpoint enable
running  out  1  state == RUN
halted  out  1  state == HALTED
halt_cause  out  2  0 none, 1 breakpoint, 2 self-loop, 3 timeout
halt_pc  out  PC_W  pcW of the halting retire; last retired PC on timeout
hit_idx  out  3  lowest matching breakpoint channel (valid when cause==1)
cycle_cnt  out  CNT_W  cycles spent in RUN
retire_cnt  out  CNT_W  instructions retired in RUN

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; last_pc=0, repeat=0. rst overrides en, clear and every halt condition, in any state.
- States: IDLE -> RUN when en=1 (the transition cycle itself is not counted). RUN -> IDLE when en=0 (pause; counters and loop tracking are held). RUN -> HALTED on a halt event. HALTED -> IDLE only when clear=1; en is ignored while HALTED.
- clear=1 in any state: counters, repeat and last_pc go to 0; halt_cause, halt_pc and hit_idx go to 0; next state IDLE. clear has priority over en and halt events.
- Counting, in RUN only: cycle_cnt +1 every cycle, including the halting cycle. retire_cnt +1 when validW=1, including the halting retire. Both saturate at all-ones and do not wrap.
- Breakpoint: on validW=1 in RUN, channel i hits when bp_en[i]=1 and pcW == channel i of bp_addr. hit_idx = lowest hitting index.
- Self-loop: on validW=1, if pcW == last_pc then repeat+1 (saturating), otherwise repeat=1; last_pc=pcW. The event fires on the retire where repeat would reach LOOP_THRESH. Cycles with validW=0 leave repeat unchanged.
- Timeout: when MAX_CYCLES != 0, the event fires on the edge where cycle_cnt becomes MAX_CYCLES.
- Simultaneous events: priority is breakpoint > self-loop > timeout. Only the winning cause is recorded.
- Halt outputs: halted, halt_cause, halt_pc and hit_idx update at the same posedge as the final counter increment (one-cycle latency from the triggering retire). They hold stable until clear or rst.
- In HALTED: counters freeze; validW, pcW and bp changes are ignored.
- bp_addr and bp_en may change at any time; they are sampled every cycle, with no shadowing.

Test Plan:
- Breakpoint: bp0=0x0000000c enabled; en=1; retire 0x0, 0x4, 0x8, 0xc on consecutive cycles -> halted=1 one cycle after the 0xc retire; cause=1, halt_pc=0xc, hit_idx=0, retire_cnt=4, cycle_cnt=4; then retire 0x10 -> counters unchanged.
- Multi-hit priority: bp1=bp3=0x20 enabled, bp0 disabled at 0x20; retire 0x20 -> hit_idx=1, cause=1.
- Self-loop: LOOP_THRESH=8; retire 0x40 eight times with validW=0 gaps between retires -> halt on the 8th retire, cause=2, halt_pc=0x40, retire_cnt=8. A different PC retired at the 7th position instead resets repeat, and no halt occurs.
- Timeout plus pause: MAX_CYCLES=10; RUN 4 cycles, en=0 for 3 cycles, then en=1 -> halts when cycle_cnt=10, cause=3; the paused cycles are not counted.
- Simultaneous events: MAX_CYCLES=5 and bp at the PC retired in cycle 5 -> cause=1.
- Reset and clear: rst=1 mid-RUN -> all outputs 0 next edge. clear in HALTED -> IDLE with zeroed outputs; en=1 then restarts counting from 0.
